// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the DLX register file.
//   DATA_W_DEF / NREGS_DEF : default register width and register count
//   reg_addr_t / reg_data_t: address and data types at default sizes
//   REG_ZERO               : index of the hardwired-zero register
package regfile_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int NREGS_DEF  = 32;
   localparam int ADDR_W_DEF = $clog2(NREGS_DEF);
   localparam int REG_ZERO   = 0;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits and their population count.
//   clk, rst           : clock, async active-high reset
//   set_en, set_addr   : accepted issue marks destination busy
//   clr_en, clr_addr   : write-back clears busy
//   busy               : stored busy vector, bit 0 always 0
//   pend_cnt           : number of busy bits currently set
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREGS  = NREGS_DEF,
   localparam int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   output logic [NREGS-1:0]  busy,
   output logic [ADDR_W:0]   pend_cnt
);
   logic             set_v, clr_v, inc, dec;
   logic [NREGS-1:0] busy_nxt;

   assign set_v = set_en && (set_addr != ADDR_W'(REG_ZERO));
   assign clr_v = clr_en && (clr_addr != ADDR_W'(REG_ZERO));

   // Count follows actual bit transitions: a set on an already-busy bit
   // adds nothing, and a clear overridden by a set on the same register
   // removes nothing.
   assign inc = set_v && !busy[set_addr];
   assign dec = clr_v && busy[clr_addr] && !(set_v && (set_addr == clr_addr));

   always_comb begin
      busy_nxt = busy;
      if (clr_v) busy_nxt[clr_addr] = 1'b0;
      if (set_v) busy_nxt[set_addr] = 1'b1;   // set applied last: new producer wins
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         busy <= busy_nxt;
         case ({inc, dec})
            2'b10:   pend_cnt <= pend_cnt + (ADDR_W+1)'(1);
            2'b01:   pend_cnt <= pend_cnt - (ADDR_W+1)'(1);
            default: pend_cnt <= pend_cnt;
         endcase
      end
   end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: DLX integer register file with NRD combinational read ports,
// one write-back port and a scoreboard that gates issue on RAW/WAW hazards.
//   clk, rst              : clock, async active-high reset
//   rd_addr/rd_use        : source addresses and which ones the instruction uses
//   rd_data/rd_busy       : read data and pending-write flag per source port
//   issue_valid/wr/rd     : issue request, writes-destination flag, destination
//   issue_ready           : issue accepted this cycle
//   wb_en/wb_addr/wb_data : write-back port
//   pend_cnt              : number of registers with a pending write
// Optional macro REGS_BYPASS_EN forwards a same-cycle write-back to readers
// and to the issue hazard check.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int NREGS  = NREGS_DEF,
   parameter  int NRD    = 2,
   localparam int ADDR_W = $clog2(NREGS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NRD-1:0][ADDR_W-1:0]  rd_addr,
   input  logic [NRD-1:0]              rd_use,
   output logic [NRD-1:0][DATA_W-1:0]  rd_data,
   output logic [NRD-1:0]              rd_busy,
   input  logic                        issue_valid,
   input  logic                        issue_wr,
   input  logic [ADDR_W-1:0]           issue_rd,
   output logic                        issue_ready,
   input  logic                        wb_en,
   input  logic [ADDR_W-1:0]           wb_addr,
   input  logic [DATA_W-1:0]           wb_data,
   output logic [ADDR_W:0]             pend_cnt
);
   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  busy;
   logic              wb_hit, wr_fwd, busy_eff_rd, hazard;

   assign wb_hit = wb_en && (wb_addr != ADDR_W'(REG_ZERO));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else if (wb_hit) begin
         regs[wb_addr] <= wb_data;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic fwd;
`ifdef REGS_BYPASS_EN
      assign fwd = wb_hit && (wb_addr == rd_addr[i]);
`else
      assign fwd = 1'b0;
`endif
      assign rd_data[i] = (rd_addr[i] == ADDR_W'(REG_ZERO)) ? '0 :
                          fwd ? wb_data : regs[rd_addr[i]];
      assign rd_busy[i] = busy[rd_addr[i]] & ~fwd;
   end

`ifdef REGS_BYPASS_EN
   assign wr_fwd = wb_hit && (wb_addr == issue_rd);
`else
   assign wr_fwd = 1'b0;
`endif
   assign busy_eff_rd = busy[issue_rd] & ~wr_fwd;

   assign hazard      = (|(rd_use & rd_busy)) | (issue_wr & busy_eff_rd);
   assign issue_ready = issue_valid & ~hazard;

   regfile_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (issue_ready & issue_wr),
      .set_addr (issue_rd),
      .clr_en   (wb_en),
      .clr_addr (wb_addr),
      .busy     (busy),
      .pend_cnt (pend_cnt)
   );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;
   import regfile_pkg::*;
   localparam int DW = 32, NR = 32, AW = 5, NRD = 2;
`ifdef REGS_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                    clk = 1'b0, rst = 1'b1;
   logic [NRD-1:0][AW-1:0]  rd_addr = '0;
   logic [NRD-1:0]          rd_use = '0;
   logic [NRD-1:0][DW-1:0]  rd_data;
   logic [NRD-1:0]          rd_busy;
   logic                    issue_valid = 1'b0, issue_wr = 1'b0, issue_ready;
   logic [AW-1:0]           issue_rd = '0;
   logic                    wb_en = 1'b0;
   logic [AW-1:0]           wb_addr = '0;
   reg_data_t               wb_data = '0;
   logic [AW:0]             pend_cnt;

   int total = 0, bad = 0;

   regfile_sb dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
      .rd_busy(rd_busy), .issue_valid(issue_valid), .issue_wr(issue_wr),
      .issue_rd(issue_rd), .issue_ready(issue_ready), .wb_en(wb_en),
      .wb_addr(wb_addr), .wb_data(wb_data), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset held: issue_ready follows issue_valid combinationally
      issue_valid = 1'b1;
      #2;
      chk("rst_ready", issue_ready, 1);
      chk("rst_pend", pend_cnt, 0);
      issue_valid = 1'b0;
      #10 rst = 1'b0;
      tick();

      // 1: reset state
      rd_addr[0] = 5'd1; rd_addr[1] = 5'd24; #1;
      chk("t1_rd0", rd_data[0], 0);
      chk("t1_rd1", rd_data[1], 0);
      chk("t1_busy", rd_busy, 0);
      chk("t1_pend", pend_cnt, 0);

      // 2: write and r0 immunity
      wb_en = 1; wb_addr = 5'd7; wb_data = 32'd111111;
      tick();
      wb_en = 0; rd_addr[0] = 5'd7; #1;
      chk("t2_r7", rd_data[0], 111111);
      chk("t2_r7_busy", rd_busy[0], 0);
      chk("t2_pend_nobusy_wb", pend_cnt, 0);
      wb_en = 1; wb_addr = 5'd0; wb_data = 32'd222222;
      tick();
      wb_en = 0; rd_addr[0] = 5'd0; #1;
      chk("t2_r0", rd_data[0], 0);
      chk("t2_r0_busy", rd_busy[0], 0);

      // 3: RAW stall and release
      issue_valid = 1; issue_wr = 1; issue_rd = 5'd3; #1;
      chk("t3_issue_wr3", issue_ready, 1);
      tick();
      issue_valid = 0; issue_wr = 0; rd_addr[0] = 5'd3; #1;
      chk("t3_busy3", rd_busy[0], 1);
      chk("t3_pend1", pend_cnt, 1);
      issue_valid = 1; rd_use = 2'b01; #1;
      chk("t3_raw_stall", issue_ready, 0);
      wb_en = 1; wb_addr = 5'd3; wb_data = 32'd444444; #1;
      chk("t3_wb_cycle_ready", issue_ready, BYP ? 1 : 0);
      chk("t3_wb_cycle_data", rd_data[0], BYP ? 444444 : 0);
      tick();
      wb_en = 0; #1;
      chk("t3_busy_clr", rd_busy[0], 0);
      chk("t3_pend0", pend_cnt, 0);
      chk("t3_r3", rd_data[0], 444444);
      chk("t3_retry", issue_ready, 1);
      issue_valid = 0; rd_use = 0;

      // 4: same-cycle write-back to a busy source
      wb_en = 1; wb_addr = 5'd10; wb_data = 32'd1010;
      tick();
      wb_en = 0; issue_valid = 1; issue_wr = 1; issue_rd = 5'd10;
      tick();
      issue_wr = 0; rd_addr[1] = 5'd10; rd_use = 2'b10;
      wb_en = 1; wb_addr = 5'd10; wb_data = 32'd555555; #1;
      chk("t4_fwd_data", rd_data[1], BYP ? 555555 : 1010);
      chk("t4_fwd_busy", rd_busy[1], BYP ? 0 : 1);
      chk("t4_fwd_ready", issue_ready, BYP ? 1 : 0);
      tick();
      wb_en = 0; #1;
      chk("t4_after_data", rd_data[1], 555555);
      chk("t4_after_busy", rd_busy[1], 0);
      chk("t4_after_ready", issue_ready, 1);
      chk("t4_pend0", pend_cnt, 0);
      issue_valid = 0; rd_use = 0;

      // 5: WAW stall and set-wins on the same edge
      issue_valid = 1; issue_wr = 1; issue_rd = 5'd13;
      tick();
      rd_addr[1] = 5'd13; #1;
      chk("t5_pend1", pend_cnt, 1);
      chk("t5_waw", issue_ready, 0);
      wb_en = 1; wb_addr = 5'd13; wb_data = 32'd1313; #1;
      chk("t5_same_edge_ready", issue_ready, BYP ? 1 : 0);
      tick();
      wb_en = 0; issue_valid = 0; issue_wr = 0; #1;
      chk("t5_busy13", rd_busy[1], BYP ? 1 : 0);
      chk("t5_pend", pend_cnt, BYP ? 1 : 0);
      chk("t5_r13", rd_data[1], 1313);

      // 6: async reset mid-cycle with three busy registers
      issue_valid = 1; issue_wr = 1;
      issue_rd = 5'd20; tick();
      issue_rd = 5'd21; tick();
      issue_rd = 5'd22; tick();
      issue_valid = 0; issue_wr = 0;
      rd_addr[0] = 5'd7; rd_addr[1] = 5'd20; #1;
      chk("t6_pend_pre", pend_cnt, BYP ? 4 : 3);
      chk("t6_busy_pre", rd_busy[1], 1);
      chk("t6_r7_pre", rd_data[0], 111111);
      #1 rst = 1; #1;
      chk("t6_pend_rst", pend_cnt, 0);
      chk("t6_rd_rst", rd_data, 0);
      chk("t6_busy_rst", rd_busy, 0);
      rd_addr[0] = 5'd3; rd_addr[1] = 5'd13; #1;
      chk("t6_rd_rst2", rd_data, 0);
      chk("t6_busy_rst2", rd_busy, 0);
      #3 rst = 0;
      tick();
      chk("t6_pend_post", pend_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
